// File: rtl/sma_window_buffer.sv
// Simple moving-average window: shift register of DEPTH samples with a running sum,
// registered sum/average result behind a valid/ready handshake.
module sma_window_buffer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH_LOG2   = 2,
    parameter int unsigned EMIT_PARTIAL = 0,
    parameter int unsigned ROUND        = 0,
    localparam int unsigned SUM_WIDTH   = DATA_WIDTH + DEPTH_LOG2,
    localparam int unsigned DEPTH       = 1 << DEPTH_LOG2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    output logic [DATA_WIDTH-1:0]         out_avg,
    output logic [SUM_WIDTH-1:0]          out_sum,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DEPTH_LOG2:0]           fill_count,
    output logic                          window_full,
    output logic [DATA_WIDTH*DEPTH-1:0]   window_data
);

    localparam logic [DEPTH_LOG2:0] FillMax  = (DEPTH_LOG2+1)'(DEPTH);
    // Half an LSB of the average; zero when truncating or when DEPTH is 1.
    localparam logic [SUM_WIDTH:0]  RoundAdd = (ROUND != 0) ? (SUM_WIDTH+1)'(DEPTH >> 1) : '0;

    typedef enum logic [0:0] {StFill, StRun} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   slot_q [DEPTH];
    logic [DATA_WIDTH-1:0]   slot_d [DEPTH];
    logic [SUM_WIDTH-1:0]    sum_q, sum_d;
    logic [SUM_WIDTH-1:0]    out_sum_q, out_sum_d;
    logic [DATA_WIDTH-1:0]   out_avg_q, out_avg_d;
    logic                    out_valid_q, out_valid_d;
    logic [DEPTH_LOG2:0]     fill_q, fill_d;
    logic [SUM_WIDTH:0]      avg_wide;
    logic                    accept;

    assign in_ready    = (!out_valid_q || out_ready) && !flush;
    assign accept      = in_valid && in_ready;
    assign out_avg     = out_avg_q;
    assign out_sum     = out_sum_q;
    assign out_valid   = out_valid_q;
    assign fill_count  = fill_q;
    assign window_full = (fill_q == FillMax);

    for (genvar k = 0; k < DEPTH; k++) begin : g_pack
        assign window_data[DATA_WIDTH*(k+1)-1 -: DATA_WIDTH] = slot_q[k];
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        sum_d       = sum_q;
        fill_d      = fill_q;
        out_sum_d   = out_sum_q;
        out_avg_d   = out_avg_q;
        out_valid_d = out_valid_q;
        avg_wide    = '0;

        if (flush) begin
            for (int k = 0; k < int'(DEPTH); k++) slot_d[k] = '0;
            sum_d       = '0;
            fill_d      = '0;
            out_sum_d   = '0;
            out_avg_d   = '0;
            out_valid_d = 1'b0;
            state_d     = StFill;
        end else if (accept) begin
            for (int k = 1; k < int'(DEPTH); k++) slot_d[k] = slot_q[k-1];
            slot_d[0] = in_data;
            // Empty slots hold zero, so subtracting the oldest is exact during fill.
            sum_d = sum_q + SUM_WIDTH'(in_data) - SUM_WIDTH'(slot_q[DEPTH-1]);
            if (fill_q != FillMax) fill_d = fill_q + 1'b1;
            case (state_q)
                StFill:  if (fill_d == FillMax) state_d = StRun;
                StRun:   state_d = StRun;
                default: state_d = StFill;
            endcase
            avg_wide    = ({1'b0, sum_d} + RoundAdd) >> DEPTH_LOG2;
            out_sum_d   = sum_d;
            out_avg_d   = avg_wide[DATA_WIDTH-1:0];
            out_valid_d = (state_d == StRun) || (EMIT_PARTIAL != 0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StFill;
            for (int k = 0; k < int'(DEPTH); k++) slot_q[k] <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            out_sum_q   <= '0;
            out_avg_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            out_sum_q   <= out_sum_d;
            out_avg_q   <= out_avg_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_sma_window_buffer.sv
// Bench for sma_window_buffer: directed scenarios plus randomized traffic checked against
// a queue-free array model that recomputes the window sum from scratch each step.
module tb_sma_window_buffer;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, out_ready;
    logic [7:0]  in_data;

    logic        d_in_ready, d_out_valid, d_full;
    logic [7:0]  d_out_avg;
    logic [9:0]  d_out_sum;
    logic [2:0]  d_fill;
    logic [31:0] d_wdata;

    logic        r_in_ready, r_out_valid, r_full;
    logic [7:0]  r_out_avg;
    logic [9:0]  r_out_sum;
    logic [2:0]  r_fill;
    logic [31:0] r_wdata;

    logic        p_in_ready, p_out_valid, p_full;
    logic [7:0]  p_out_avg;
    logic [9:0]  p_out_sum;
    logic [2:0]  p_fill;
    logic [31:0] p_wdata;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int win[4];
    int mcnt, msum, mavg, mravg;
    bit mvalid;
    bit exp_ready, obs_ready;

    always #5 clk = ~clk;

    sma_window_buffer #(.DATA_WIDTH(8), .DEPTH_LOG2(2), .EMIT_PARTIAL(0), .ROUND(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(d_in_ready), .flush(flush), .out_avg(d_out_avg), .out_sum(d_out_sum),
        .out_valid(d_out_valid), .out_ready(out_ready), .fill_count(d_fill),
        .window_full(d_full), .window_data(d_wdata)
    );

    sma_window_buffer #(.DATA_WIDTH(8), .DEPTH_LOG2(2), .EMIT_PARTIAL(0), .ROUND(1)) dut_round (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r_in_ready), .flush(flush), .out_avg(r_out_avg), .out_sum(r_out_sum),
        .out_valid(r_out_valid), .out_ready(out_ready), .fill_count(r_fill),
        .window_full(r_full), .window_data(r_wdata)
    );

    sma_window_buffer #(.DATA_WIDTH(8), .DEPTH_LOG2(2), .EMIT_PARTIAL(1), .ROUND(0)) dut_part (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(p_in_ready), .flush(flush), .out_avg(p_out_avg), .out_sum(p_out_sum),
        .out_valid(p_out_valid), .out_ready(out_ready), .fill_count(p_fill),
        .window_full(p_full), .window_data(p_wdata)
    );

    function automatic logic [31:0] exp_wdata();
        return {8'(win[3]), 8'(win[2]), 8'(win[1]), 8'(win[0])};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) win[i] = 0;
        mcnt = 0; msum = 0; mavg = 0; mravg = 0; mvalid = 1'b0;
    endtask

    // Drive one cycle of inputs, capture in_ready before the edge, advance the model.
    task automatic drive_cycle(input bit v, input int d, input bit ordy, input bit fl,
                               input bit rst);
        bit acc;
        @(negedge clk);
        in_valid = v; in_data = 8'(d); out_ready = ordy; flush = fl; rst_n = rst;
        #1;
        exp_ready = (!mvalid || ordy) && !fl;
        obs_ready = d_in_ready;
        acc = v && exp_ready;
        @(posedge clk);
        if (!rst || fl) begin
            model_clear();
        end else if (acc) begin
            for (int i = 3; i > 0; i--) win[i] = win[i-1];
            win[0] = d;
            if (mcnt < 4) mcnt++;
            msum = win[0] + win[1] + win[2] + win[3];
            mavg = msum / 4;
            mravg = (msum + 2) / 4;
            mvalid = (mcnt == 4);
        end else if (ordy) begin
            mvalid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1, 55, 1, 1, 0);
        drive_cycle(1, 77, 0, 0, 0);
        n_cmp++; if (d_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", d_out_valid); end
        n_cmp++; if (d_fill !== 3'd0) begin n_err++; $display("FAIL reset_fill got %0d want 0", d_fill); end
        n_cmp++; if (d_out_sum !== 10'd0 || d_out_avg !== 8'd0) begin n_err++; $display("FAIL reset_result got sum %0d avg %0d want 0 0", d_out_sum, d_out_avg); end
        n_cmp++; if (d_full !== 1'b0 || d_wdata !== 32'd0) begin n_err++; $display("FAIL reset_window got full %b data %h want 0 0", d_full, d_wdata); end
    endtask

    task automatic test_fill();
        int vals[3] = '{10, 20, 30};
        drive_cycle(0, 0, 1, 0, 1);
        foreach (vals[i]) begin
            drive_cycle(1, vals[i], 1, 0, 1);
            n_cmp++; if (d_out_valid !== 1'b0) begin n_err++; $display("FAIL fill_noval%0d got %b want 0", i, d_out_valid); end
        end
        drive_cycle(1, 40, 1, 0, 1);
        n_cmp++; if (d_out_valid !== 1'b1) begin n_err++; $display("FAIL fill_valid got %b want 1", d_out_valid); end
        n_cmp++; if (d_out_sum !== 10'd100) begin n_err++; $display("FAIL fill_sum got %0d want 100", d_out_sum); end
        n_cmp++; if (d_out_avg !== 8'd25) begin n_err++; $display("FAIL fill_avg got %0d want 25", d_out_avg); end
        n_cmp++; if (d_full !== 1'b1 || d_wdata[7:0] !== 8'd40) begin n_err++; $display("FAIL fill_window got full %b slot0 %0d want 1 40", d_full, d_wdata[7:0]); end
    endtask

    task automatic test_slide();
        drive_cycle(1, 50, 1, 0, 1);
        n_cmp++; if (d_out_sum !== 10'd140 || d_out_avg !== 8'd35) begin n_err++; $display("FAIL slide_result got sum %0d avg %0d want 140 35", d_out_sum, d_out_avg); end
        n_cmp++; if (d_wdata !== 32'h141E_2832) begin n_err++; $display("FAIL slide_window got %h want 141e2832", d_wdata); end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < 4; i++) drive_cycle(1, 255, 1, 0, 1);
        n_cmp++; if (d_out_sum !== 10'd1020 || d_out_avg !== 8'd255) begin n_err++; $display("FAIL max_result got sum %0d avg %0d want 1020 255", d_out_sum, d_out_avg); end
        drive_cycle(1, 0, 1, 0, 1);
        n_cmp++; if (d_out_sum !== 10'd765 || d_out_avg !== 8'd191) begin n_err++; $display("FAIL drop_result got sum %0d avg %0d want 765 191", d_out_sum, d_out_avg); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1, 7, 0, 0, 1);
            n_cmp++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready%0d got %b want 0", i, obs_ready); end
            n_cmp++; if (d_out_valid !== 1'b1 || d_out_sum !== 10'd765 || d_out_avg !== 8'd191 || d_fill !== 3'd4)
                begin n_err++; $display("FAIL bp_hold%0d got v %b sum %0d avg %0d fill %0d want 1 765 191 4", i, d_out_valid, d_out_sum, d_out_avg, d_fill); end
        end
        drive_cycle(1, 7, 1, 0, 1);
        n_cmp++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL bp_resume_ready got %b want 1", obs_ready); end
        n_cmp++; if (d_out_valid !== 1'b1 || d_out_sum !== 10'd517 || d_out_avg !== 8'd129)
            begin n_err++; $display("FAIL bp_resume got v %b sum %0d avg %0d want 1 517 129", d_out_valid, d_out_sum, d_out_avg); end
    endtask

    task automatic test_flush();
        drive_cycle(0, 0, 1, 1, 1);
        drive_cycle(1, 3, 1, 0, 1);
        drive_cycle(1, 5, 1, 0, 1);
        n_cmp++; if (d_fill !== 3'd2) begin n_err++; $display("FAIL flush_pre_fill got %0d want 2", d_fill); end
        drive_cycle(1, 9, 1, 1, 1);
        n_cmp++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b want 0", obs_ready); end
        n_cmp++; if (d_fill !== 3'd0 || d_out_sum !== 10'd0 || d_out_valid !== 1'b0 || d_wdata !== 32'd0)
            begin n_err++; $display("FAIL flush_clear got fill %0d sum %0d v %b data %h want 0 0 0 0", d_fill, d_out_sum, d_out_valid, d_wdata); end
        for (int i = 1; i <= 4; i++) drive_cycle(1, i, 1, 0, 1);
        n_cmp++; if (d_full !== 1'b1 || d_out_sum !== 10'd10) begin n_err++; $display("FAIL refill got full %b sum %0d want 1 10", d_full, d_out_sum); end
        drive_cycle(1, 9, 1, 0, 0);
        n_cmp++; if (d_fill !== 3'd0 || d_out_sum !== 10'd0 || d_out_avg !== 8'd0 || d_out_valid !== 1'b0 || d_full !== 1'b0 || d_wdata !== 32'd0)
            begin n_err++; $display("FAIL run_reset got fill %0d sum %0d avg %0d v %b full %b data %h want all 0", d_fill, d_out_sum, d_out_avg, d_out_valid, d_full, d_wdata); end
    endtask

    task automatic test_round();
        int vals[4] = '{1, 2, 2, 2};
        drive_cycle(0, 0, 1, 0, 0);
        foreach (vals[i]) drive_cycle(1, vals[i], 1, 0, 1);
        n_cmp++; if (r_out_sum !== 10'd7 || r_out_avg !== 8'd2) begin n_err++; $display("FAIL round_up got sum %0d avg %0d want 7 2", r_out_sum, r_out_avg); end
        n_cmp++; if (d_out_avg !== 8'd1) begin n_err++; $display("FAIL round_trunc got avg %0d want 1", d_out_avg); end
    endtask

    task automatic test_partial();
        drive_cycle(0, 0, 1, 0, 0);
        drive_cycle(1, 8, 1, 0, 1);
        n_cmp++; if (p_out_valid !== 1'b1 || p_out_sum !== 10'd8 || p_out_avg !== 8'd2)
            begin n_err++; $display("FAIL partial got v %b sum %0d avg %0d want 1 8 2", p_out_valid, p_out_sum, p_out_avg); end
        n_cmp++; if (d_out_valid !== 1'b0) begin n_err++; $display("FAIL partial_off got v %b want 0", d_out_valid); end
    endtask

    task automatic test_random();
        bit v, ordy, fl, rst;
        int d;
        drive_cycle(0, 0, 1, 0, 0);
        for (int c = 0; c < 400; c++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 31) == 0);
            rst  = ($urandom_range(0, 99) != 0);
            d    = $urandom_range(0, 255);
            drive_cycle(v, d, ordy, fl, rst);
            n_cmp++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready c%0d got %b want %b", c, obs_ready, exp_ready); end
            n_cmp++; if (d_out_valid !== mvalid) begin n_err++; $display("FAIL rnd_valid c%0d got %b want %b", c, d_out_valid, mvalid); end
            n_cmp++; if (d_fill !== 3'(mcnt) || d_full !== (mcnt == 4)) begin n_err++; $display("FAIL rnd_fill c%0d got %0d/%b want %0d", c, d_fill, d_full, mcnt); end
            n_cmp++; if (d_wdata !== exp_wdata()) begin n_err++; $display("FAIL rnd_window c%0d got %h want %h", c, d_wdata, exp_wdata()); end
            if (mvalid) begin
                n_cmp++; if (d_out_sum !== 10'(msum) || d_out_avg !== 8'(mavg))
                    begin n_err++; $display("FAIL rnd_result c%0d got %0d/%0d want %0d/%0d", c, d_out_sum, d_out_avg, msum, mavg); end
                n_cmp++; if (r_out_avg !== 8'(mravg)) begin n_err++; $display("FAIL rnd_round c%0d got %0d want %0d", c, r_out_avg, mravg); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
        model_clear();
        test_reset();
        test_fill();
        test_slide();
        test_extremes();
        test_backpressure();
        test_flush();
        test_round();
        test_partial();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sma_window_buffer.md
SMA_WINDOW_BUFFER -- requirements
Module: sma_window_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, sample width in bits (unsigned).
REQ-002 SHALL have parameter DEPTH_LOG2, default 2, window depth DEPTH = 2^DEPTH_LOG2 (range 0..6).
REQ-003 SHALL have parameter EMIT_PARTIAL, default 0; 1 = emit a result on every accepted sample, 0 = emit only when the window is full.
REQ-004 SHALL have parameter ROUND, default 0; 0 = truncate average, 1 = round half up.
REQ-005 SHALL derive SUM_WIDTH = DATA_WIDTH + DEPTH_LOG2 internally.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 in_data  input  DATA_WIDTH  sample.
REQ-009 in_valid  input  1  sample present.
REQ-010 in_ready  output  1  block can accept a sample.
REQ-011 flush  input  1  clear window and pending result.
REQ-012 out_avg  output  DATA_WIDTH  window average.
REQ-013 out_sum  output  SUM_WIDTH  window sum.
REQ-014 out_valid  output  1  result present.
REQ-015 out_ready  input  1  consumer takes result.
REQ-016 fill_count  output  DEPTH_LOG2+1  samples held, saturating at DEPTH.
REQ-017 window_full  output  1  fill_count == DEPTH.
REQ-018 window_data  output  DATA_WIDTH*DEPTH  packed window; slot k at [DATA_WIDTH*(k+1)-1 -: DATA_WIDTH]; slot 0 is newest.

Function
REQ-019 Accept SHALL occur when in_valid && in_ready at a rising edge.
REQ-020 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-021 On accept: slot k <= slot k-1 for k>0; slot 0 <= in_data; the oldest slot is discarded.
REQ-022 Running sum on accept SHALL be sum + in_data - slot[DEPTH-1]; empty slots hold 0, so the sum is exact during fill.
REQ-023 The sum SHALL never overflow SUM_WIDTH; no saturation logic is required.
REQ-024 Average SHALL be sum >> DEPTH_LOG2 (ROUND=0) or (sum + 2^(DEPTH_LOG2-1)) >> DEPTH_LOG2 (ROUND=1, DEPTH_LOG2>0), evaluated at SUM_WIDTH+1 bits and then truncated to DATA_WIDTH.
REQ-025 The control FSM SHALL have two states: FILL (fill_count < DEPTH) and RUN (window full). FILL->RUN on the accept that makes fill_count = DEPTH. RUN->FILL only on flush or reset.
REQ-026 Latency SHALL be 1 cycle: out_sum and out_avg reflect the post-accept window in the cycle after the accept, with out_valid=1 if (state after accept is RUN) || EMIT_PARTIAL.
REQ-027 out_valid, out_sum and out_avg SHALL hold stable while out_valid && !out_ready.
REQ-028 out_valid SHALL clear on out_ready unless a new result loads in the same edge; a simultaneous accept and out_ready SHALL give back-to-back results.
REQ-029 flush SHALL override an accept in the same cycle: the sample is dropped, and next cycle all slots, sum, fill_count and out_valid are 0 and the state is FILL.
REQ-030 fill_count SHALL increment per accept up to DEPTH and then hold.

Reset
REQ-031 With rst_n low at an edge: all slots, sum, out_sum, out_avg, fill_count = 0; out_valid = 0; window_full = 0; state = FILL. This applies regardless of in_valid or flush.
REQ-032 Reset mid-operation SHALL discard any pending result and all window contents.

Verification (DATA_WIDTH=8, DEPTH_LOG2=2 unless stated)
REQ-033 Fill: reset, out_ready=1, accept 10,20,30,40 -> no out_valid for the first three; the cycle after 40: out_valid=1, out_sum=100, out_avg=25, window_full=1, window_data[7:0]=40.
REQ-034 Slide: then accept 50 -> out_sum=140, out_avg=35, window_data = {10'dropped}: slots 50,40,30,20.
REQ-035 Extremes: accept 255 four times -> out_sum=1020, out_avg=255; then accept 0 -> out_sum=765, out_avg=191.
REQ-036 Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, in_valid beats are not accepted, outputs are unchanged for 5 cycles; raising out_ready -> accept resumes the same cycle.
REQ-037 Flush/reset: after 2 accepts, flush=1 with in_valid=1 -> next cycle fill_count=0, out_sum=0, out_valid=0. Repeat with rst_n=0 for 1 cycle in RUN -> the same all-zero state.
REQ-038 ROUND=1: accept 1,2,2,2 -> out_sum=7, out_avg=2 (ROUND=0 gives 1). EMIT_PARTIAL=1: first accept of 8 -> out_valid=1, out_sum=8, out_avg=2.
